// File: rtl/hbridge_pattern_sequencer.sv
// rtl/hbridge_pattern_sequencer.sv - H-bridge pattern sequencer with dead-time insertion
// Steps through a programmable table of per-channel bridge codes in one-shot, repeat or ping-pong order.
module hbridge_pattern_sequencer #(
  parameter int NUM_OF_DRIVERS     = 16,
  parameter int MEM_LENGTH         = 48,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int HOLD_WIDTH         = 8,
  parameter int DEAD_WIDTH         = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            mem_write_n,
  input  logic [MEM_ADDRESS_LENGTH-1:0]   mem_address,
  input  logic [2*NUM_OF_DRIVERS-1:0]     mem_data,
  input  logic [HOLD_WIDTH-1:0]           mem_hold,
  input  logic                            write_config_n,
  input  logic [1:0]                      config_address,
  input  logic [15:0]                     config_data,
  input  logic                            control_trigger,
  input  logic                            abort,
  output logic [2*NUM_OF_DRIVERS-1:0]     driver_io,
  output logic                            busy,
  output logic [MEM_ADDRESS_LENGTH-1:0]   step_index,
  output logic                            dead_active,
  output logic                            update_cycle_complete
);
  localparam int DW = 2 * NUM_OF_DRIVERS;
  localparam logic [MEM_ADDRESS_LENGTH-1:0] LAST_MAX = MEM_ADDRESS_LENGTH'(MEM_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;

  logic [DW-1:0]         code_mem [MEM_LENGTH];
  logic [HOLD_WIDTH-1:0] hold_mem [MEM_LENGTH];

  logic [MEM_ADDRESS_LENGTH-1:0] last_step;
  logic [1:0]                    mode;
  logic [DEAD_WIDTH-1:0]         dead_time;
  logic [15:0]                   repeat_count;

  state_t                        state, state_d;
  logic [DW-1:0]                 drv_d;
  logic [MEM_ADDRESS_LENGTH-1:0] idx_d, nxt;
  logic [HOLD_WIDTH-1:0]         hold_cnt, cnt_d;
  logic [DEAD_WIDTH-1:0]         dead_cnt, dcnt_d;
  logic [15:0]                   pass_cnt, pass_d;
  logic                          dir, dir_d, dir_n;
  logic                          at_last, at_first, pass_end, done, complete, any_changed;
  logic [DW-1:0]                 new_drv, dead_drv;

  // code {b1,b0} drives {p,n} = {b0,b1}: 01 -> fwd {1,0}, 10 -> rev {0,1}
  function automatic logic [DW-1:0] to_drive(input logic [DW-1:0] c);
    logic [DW-1:0] r;
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      r[2*i+1] = c[2*i];
      r[2*i]   = c[2*i+1];
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (!mem_write_n && int'(mem_address) < MEM_LENGTH) begin
      code_mem[mem_address] <= mem_data;
      hold_mem[mem_address] <= mem_hold;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_step    <= '0;
      mode         <= '0;
      dead_time    <= '0;
      repeat_count <= '0;
    end else if (!write_config_n && state == IDLE) begin
      case (config_address)
        2'd0: last_step <= (int'(config_data) > MEM_LENGTH - 1) ? LAST_MAX
                                                                 : config_data[MEM_ADDRESS_LENGTH-1:0];
        2'd1: mode <= config_data[1:0];
        2'd2: dead_time <= config_data[DEAD_WIDTH-1:0];
        default: repeat_count <= config_data;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      driver_io  <= '0;
      step_index <= '0;
      hold_cnt   <= '0;
      dead_cnt   <= '0;
      pass_cnt   <= '0;
      dir        <= 1'b0;
    end else begin
      state      <= state_d;
      driver_io  <= drv_d;
      step_index <= idx_d;
      hold_cnt   <= cnt_d;
      dead_cnt   <= dcnt_d;
      pass_cnt   <= pass_d;
      dir        <= dir_d;
    end
  end

  always_comb begin
    state_d  = state;
    drv_d    = driver_io;
    idx_d    = step_index;
    cnt_d    = hold_cnt;
    dcnt_d   = dead_cnt;
    pass_d   = pass_cnt;
    dir_d    = dir;
    complete = 1'b0;
    at_last  = (step_index == last_step);
    at_first = (step_index == '0);
    pass_end = (mode == 2'd2) ? (dir ? at_first : at_last) : at_last;
    done     = (mode[0] == mode[1]) || (repeat_count != '0 && pass_cnt == repeat_count);

    // dir=1 is the descending half of a ping-pong pass; endpoints are visited once per turn
    dir_n = dir;
    if (mode == 2'd2) begin
      if (!dir && at_last) begin
        nxt   = (last_step == '0) ? step_index : step_index - MEM_ADDRESS_LENGTH'(1);
        dir_n = (last_step != '0);
      end else if (dir && at_first) begin
        nxt   = step_index + MEM_ADDRESS_LENGTH'(1);
        dir_n = 1'b0;
      end else begin
        nxt = dir ? step_index - MEM_ADDRESS_LENGTH'(1) : step_index + MEM_ADDRESS_LENGTH'(1);
      end
    end else begin
      nxt = at_last ? '0 : step_index + MEM_ADDRESS_LENGTH'(1);
    end

    new_drv     = to_drive(code_mem[nxt]);
    dead_drv    = new_drv;
    any_changed = 1'b0;
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      if (driver_io[2*i+1 -: 2] != 2'b00 && new_drv[2*i+1 -: 2] != driver_io[2*i+1 -: 2]) begin
        any_changed          = 1'b1;
        dead_drv[2*i+1 -: 2] = 2'b00;
      end
    end

    case (state)
      IDLE: begin
        drv_d = '0;
        if (control_trigger) begin
          state_d = RUN;
          idx_d   = '0;
          drv_d   = to_drive(code_mem[0]);
          cnt_d   = hold_mem[0];
          dir_d   = 1'b0;
          pass_d  = 16'd1;
        end
      end
      RUN: begin
        if (hold_cnt != '0) begin
          cnt_d = hold_cnt - HOLD_WIDTH'(1);
        end else begin
          complete = pass_end;
          if (pass_end && done) begin
            state_d = IDLE;
            drv_d   = '0;
          end else begin
            if (pass_end) pass_d = pass_cnt + 16'd1;
            idx_d = nxt;
            dir_d = dir_n;
            cnt_d = hold_mem[nxt];
            if (any_changed && dead_time != '0) begin
              state_d = DEAD;
              drv_d   = dead_drv;
              dcnt_d  = dead_time - DEAD_WIDTH'(1);
            end else begin
              drv_d = new_drv;
            end
          end
        end
      end
      DEAD: begin
        if (dead_cnt != '0) begin
          dcnt_d = dead_cnt - DEAD_WIDTH'(1);
        end else begin
          state_d = RUN;
          drv_d   = to_drive(code_mem[step_index]);
          cnt_d   = hold_mem[step_index];
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d  = IDLE;
      drv_d    = '0;
      complete = 1'b0;
    end
  end

  assign busy                  = (state != IDLE);
  assign dead_active           = (state == DEAD);
  assign update_cycle_complete = complete;
endmodule

// File: tb/tb_hbridge_pattern_sequencer.sv
// tb/tb_hbridge_pattern_sequencer.sv - directed table-driven bench for hbridge_pattern_sequencer
module tb_hbridge_pattern_sequencer;
  localparam int N  = 16;
  localparam int ML = 48;
  localparam int AW = 6;
  localparam int HW = 8;
  localparam int DT = 4;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            mem_write_n = 1'b1;
  logic [AW-1:0]   mem_address = '0;
  logic [2*N-1:0]  mem_data = '0;
  logic [HW-1:0]   mem_hold = '0;
  logic            write_config_n = 1'b1;
  logic [1:0]      config_address = '0;
  logic [15:0]     config_data = '0;
  logic            control_trigger = 1'b0;
  logic            abort = 1'b0;
  logic [2*N-1:0]  driver_io;
  logic            busy;
  logic [AW-1:0]   step_index;
  logic            dead_active;
  logic            update_cycle_complete;

  hbridge_pattern_sequencer #(
    .NUM_OF_DRIVERS(N), .MEM_LENGTH(ML), .MEM_ADDRESS_LENGTH(AW),
    .HOLD_WIDTH(HW), .DEAD_WIDTH(DT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mem_write_n(mem_write_n), .mem_address(mem_address),
    .mem_data(mem_data), .mem_hold(mem_hold), .write_config_n(write_config_n),
    .config_address(config_address), .config_data(config_data),
    .control_trigger(control_trigger), .abort(abort), .driver_io(driver_io), .busy(busy),
    .step_index(step_index), .dead_active(dead_active),
    .update_cycle_complete(update_cycle_complete)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        trig;
    logic        abrt;
    logic        cfg;
    logic [1:0]  caddr;
    logic [15:0] cdata;
    logic [3:0]  drv;
    logic        busy;
    logic        dead;
    logic        cmpl;
    logic [5:0]  step;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  function automatic vec_t v(input logic trig, input logic abrt, input logic [3:0] drv,
                             input logic bsy, input logic dead, input logic cmpl, input logic [5:0] step);
    vec_t r;
    r.trig = trig; r.abrt = abrt; r.cfg = 1'b0; r.caddr = 2'd0; r.cdata = 16'd0;
    r.drv = drv; r.busy = bsy; r.dead = dead; r.cmpl = cmpl; r.step = step;
    return r;
  endfunction

  // each row: inputs applied at a falling edge, outputs of that same cycle compared 1ns later
  task automatic run_vecs(input string name);
    foreach (vecs[i]) begin
      control_trigger = vecs[i].trig;
      abort           = vecs[i].abrt;
      write_config_n  = !vecs[i].cfg;
      config_address  = vecs[i].caddr;
      config_data     = vecs[i].cdata;
      #1;
      check({name, ".drv"},   i, 32'(driver_io[3:0]), 32'(vecs[i].drv));
      check({name, ".upper"}, i, 32'(driver_io[2*N-1:4]), 32'd0);
      check({name, ".busy"},  i, 32'(busy), 32'(vecs[i].busy));
      check({name, ".dead"},  i, 32'(dead_active), 32'(vecs[i].dead));
      check({name, ".cmpl"},  i, 32'(update_cycle_complete), 32'(vecs[i].cmpl));
      check({name, ".step"},  i, 32'(step_index), 32'(vecs[i].step));
      @(negedge clock);
    end
    control_trigger = 1'b0;
    abort           = 1'b0;
    write_config_n  = 1'b1;
    vecs.delete();
  endtask

  task automatic write_step(input int addr, input logic [3:0] code, input int hold);
    mem_write_n = 1'b0;
    mem_address = AW'(addr);
    mem_data    = {28'd0, code};
    mem_hold    = HW'(hold);
    @(negedge clock);
    mem_write_n = 1'b1;
  endtask

  task automatic write_cfg(input logic [1:0] addr, input int data);
    write_config_n = 1'b0;
    config_address = addr;
    config_data    = 16'(data);
    @(negedge clock);
    write_config_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[10];
    vec_t r;
    int n, got, s;

    repeat (2) @(negedge clock);
    #1;
    check("reset.drv",  0, driver_io, 32'd0);
    check("reset.busy", 0, 32'(busy), 32'd0);
    check("reset.step", 0, 32'(step_index), 32'd0);
    check("reset.cmpl", 0, 32'(update_cycle_complete), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // one-shot, holds 3/0/1, ch0 fwd -> rev -> off, no dead time
    write_step(0, 4'b0001, 3);
    write_step(1, 4'b0010, 0);
    write_step(2, 4'b0000, 1);
    write_cfg(2'd0, 2);
    vecs.push_back(v(1, 0, 4'b0000, 0, 0, 0, 0));
    repeat (4) vecs.push_back(v(0, 0, 4'b0010, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 4'b0001, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 4'b0000, 1, 0, 0, 2));
    vecs.push_back(v(0, 0, 4'b0000, 1, 0, 1, 2));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 2));
    run_vecs("oneshot");

    // dead time 3: ch0 fwd->rev is blanked, ch1 fwd->fwd keeps driving
    write_step(0, 4'b0101, 1);
    write_step(1, 4'b0110, 0);
    write_cfg(2'd0, 1);
    write_cfg(2'd2, 3);
    vecs.push_back(v(1, 0, 4'b0000, 0, 0, 0, 2));
    repeat (2) vecs.push_back(v(0, 0, 4'b1010, 1, 0, 0, 0));
    repeat (3) vecs.push_back(v(0, 0, 4'b1000, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 4'b1001, 1, 0, 1, 1));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 1));
    run_vecs("dead");

    // abort in DEAD together with a trigger
    vecs.push_back(v(1, 0, 4'b0000, 0, 0, 0, 1));
    repeat (2) vecs.push_back(v(0, 0, 4'b1010, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 4'b1000, 1, 1, 0, 1));
    vecs.push_back(v(1, 1, 4'b1000, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 1));
    run_vecs("abort_dead");

    // abort on the pass-end cycle suppresses the pulse
    vecs.push_back(v(1, 0, 4'b0000, 0, 0, 0, 1));
    repeat (2) vecs.push_back(v(0, 0, 4'b1010, 1, 0, 0, 0));
    repeat (3) vecs.push_back(v(0, 0, 4'b1000, 1, 1, 0, 1));
    vecs.push_back(v(0, 1, 4'b1001, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 1));
    run_vecs("abort_end");

    // ping-pong over 0..3, three passes
    for (int k = 0; k < 4; k++) write_step(k, 4'b0001, 0);
    write_cfg(2'd0, 3);
    write_cfg(2'd1, 2);
    write_cfg(2'd2, 0);
    write_cfg(2'd3, 3);
    seq = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
    vecs.push_back(v(1, 0, 4'b0000, 0, 0, 0, 1));
    for (int k = 0; k < 10; k++)
      vecs.push_back(v(0, 0, 4'b0010, 1, 0, (k == 3 || k == 6 || k == 9), 6'(seq[k])));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 3));
    run_vecs("pingpong");

    // config write while busy must be ignored
    write_cfg(2'd0, 2);
    write_cfg(2'd1, 0);
    write_cfg(2'd3, 0);
    vecs.push_back(v(1, 0, 4'b0000, 0, 0, 0, 3));
    r = v(0, 0, 4'b0010, 1, 0, 0, 0);
    r.cfg = 1'b1; r.caddr = 2'd0; r.cdata = 16'd5;
    vecs.push_back(r);
    vecs.push_back(v(0, 0, 4'b0010, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 4'b0010, 1, 0, 1, 2));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 2));
    run_vecs("busy_cfg");

    // last_step=63 clamps to 47: a 48-cycle pass ending on step 47
    for (int k = 0; k < ML; k++) write_step(k, 4'b0001, 0);
    write_cfg(2'd0, 63);
    control_trigger = 1'b1;
    @(negedge clock);
    control_trigger = 1'b0;
    n = 0; got = 0; s = 0;
    for (int i = 1; i <= 100 && got == 0; i++) begin
      #1;
      if (update_cycle_complete) begin
        got = 1; n = i; s = int'(step_index);
      end
      @(negedge clock);
    end
    check("clamp.pulse", 0, 32'(got), 32'd1);
    check("clamp.len",   0, 32'(n), 32'd48);
    check("clamp.step",  0, 32'(s), 32'd47);
    @(negedge clock);

    // asynchronous reset in the middle of a repeating run
    write_cfg(2'd0, 2);
    write_cfg(2'd1, 1);
    write_cfg(2'd2, 5);
    control_trigger = 1'b1;
    @(negedge clock);
    control_trigger = 1'b0;
    @(negedge clock);
    #1;
    check("prereset.busy", 0, 32'(busy), 32'd1);
    check("prereset.drv",  0, 32'(driver_io[3:0]), 32'h2);
    #1;
    reset_n = 1'b0;
    #1;
    check("async.drv",  0, driver_io, 32'd0);
    check("async.busy", 0, 32'(busy), 32'd0);
    check("async.step", 0, 32'(step_index), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    // defaults: last_step 0, one-shot, so a trigger gives a single one-cycle pass
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 4'b0010, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 4'b0000, 0, 0, 0, 0));
    run_vecs("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
